// File: rtl/ped_signal_ctl.sv
// Pedestrian crossing controller downstream of the intersection lamp controller.
// Two independent crosswalk FSMs (A across road A, B across road B) grant WALK
// and flashing DON'T-WALK only inside the red phase of the crossed road. A sticky
// fault latches on any illegal lamp pattern.
module ped_signal_ctl #(
    parameter int unsigned WALK_CYC  = 2,
    parameter int unsigned FLASH_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] TL,
    input  logic       btn_a,
    input  logic       btn_b,
    output logic [1:0] ped_a,
    output logic [1:0] ped_b,
    output logic [3:0] cnt_a,
    output logic [3:0] cnt_b,
    output logic       req_a,
    output logic       req_b,
    output logic       cut_a,
    output logic       cut_b,
    output logic       fault
);

    localparam int unsigned CW = 4;
    localparam int unsigned NX = 2;  // index 0 = crosswalk A, 1 = crosswalk B

    localparam logic [1:0] PED_DARK  = 2'b00;
    localparam logic [1:0] PED_DONT  = 2'b01;
    localparam logic [1:0] PED_WALK  = 2'b10;
    localparam logic [1:0] PED_FLASH = 2'b11;

    typedef enum logic [1:0] {
        ST_DONT  = 2'd0,
        ST_WALK  = 2'd1,
        ST_FLASH = 2'd2
    } xw_state_e;

    xw_state_e         st_q    [NX];
    xw_state_e         st_d    [NX];
    logic [CW-1:0]     tmr_q   [NX];
    logic [CW-1:0]     tmr_d   [NX];
    logic [CW-1:0]     disp_q  [NX];
    logic [CW-1:0]     disp_d  [NX];
    logic [1:0]        ped_q   [NX];
    logic [1:0]        ped_d   [NX];
    logic [NX-1:0]     req_q, req_d;
    logic [NX-1:0]     cut_q, cut_d;
    logic [NX-1:0]     prev_red_q;
    logic              fault_q, fault_d;

    logic [NX-1:0]     red_c;
    logic [NX-1:0]     red_start_c;
    logic [NX-1:0]     btn_c;
    logic              dark_c;
    logic              bad_c;

    function automatic logic onehot3(input logic [2:0] g);
        return (g == 3'b001) || (g == 3'b010) || (g == 3'b100);
    endfunction

    assign red_c       = {TL[2], TL[5]};
    assign btn_c       = {btn_b, btn_a};
    assign red_start_c = red_c & ~prev_red_q;
    assign dark_c      = (TL == 6'b000000);
    assign bad_c       = !dark_c &&
                         (!onehot3(TL[5:3]) || !onehot3(TL[2:0]) || (TL[3] && TL[0]));

    // Next-state and next-output computation for both crosswalks
    always_comb begin
        fault_d = fault_q | bad_c;
        req_d   = req_q;
        cut_d   = '0;
        for (int i = 0; i < NX; i++) begin
            st_d[i]   = st_q[i];
            tmr_d[i]  = tmr_q[i];
            ped_d[i]  = PED_DONT;
            disp_d[i] = '0;

            if (fault_d || dark_c) begin
                st_d[i]  = ST_DONT;
                tmr_d[i] = '0;
                req_d[i] = 1'b0;
            end else begin
                case (st_q[i])
                    ST_WALK: begin
                        if (!red_c[i]) begin
                            st_d[i]  = ST_DONT;
                            tmr_d[i] = '0;
                            cut_d[i] = 1'b1;
                        end else if (tmr_q[i] == '0) begin
                            st_d[i]  = ST_FLASH;
                            tmr_d[i] = CW'(FLASH_CYC - 1);
                        end else begin
                            tmr_d[i] = tmr_q[i] - CW'(1);
                        end
                    end
                    ST_FLASH: begin
                        if (!red_c[i]) begin
                            st_d[i]  = ST_DONT;
                            tmr_d[i] = '0;
                            cut_d[i] = 1'b1;
                        end else if (tmr_q[i] == '0) begin
                            st_d[i] = ST_DONT;
                        end else begin
                            tmr_d[i] = tmr_q[i] - CW'(1);
                        end
                    end
                    default: begin
                        st_d[i] = ST_DONT;
                        if (red_start_c[i] && (req_q[i] || btn_c[i])) begin
                            st_d[i]  = ST_WALK;
                            tmr_d[i] = CW'(WALK_CYC - 1);
                            req_d[i] = 1'b0;
                        end else begin
                            req_d[i] = req_q[i] | btn_c[i];
                        end
                    end
                endcase
            end

            if (fault_d) begin
                ped_d[i] = PED_DONT;
            end else if (dark_c) begin
                ped_d[i] = PED_DARK;
            end else begin
                case (st_d[i])
                    ST_WALK:  ped_d[i] = PED_WALK;
                    ST_FLASH: begin
                        ped_d[i]  = PED_FLASH;
                        disp_d[i] = tmr_d[i] + CW'(1);
                    end
                    default:  ped_d[i] = PED_DONT;
                endcase
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NX; i++) begin
                st_q[i]   <= ST_DONT;
                tmr_q[i]  <= '0;
                disp_q[i] <= '0;
                ped_q[i]  <= PED_DARK;
            end
            req_q      <= '0;
            cut_q      <= '0;
            prev_red_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NX; i++) begin
                st_q[i]   <= st_d[i];
                tmr_q[i]  <= tmr_d[i];
                disp_q[i] <= disp_d[i];
                ped_q[i]  <= ped_d[i];
            end
            req_q      <= req_d;
            cut_q      <= cut_d;
            prev_red_q <= red_c;
            fault_q    <= fault_d;
        end
    end

    assign ped_a = ped_q[0];
    assign ped_b = ped_q[1];
    assign cnt_a = disp_q[0];
    assign cnt_b = disp_q[1];
    assign req_a = req_q[0];
    assign req_b = req_q[1];
    assign cut_a = cut_q[0];
    assign cut_b = cut_q[1];
    assign fault = fault_q;

endmodule

// File: tb/tb_ped_signal_ctl.sv
// Directed bench for ped_signal_ctl with an expected-value queue.
module tb_ped_signal_ctl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] TL;
    logic       btn_a, btn_b;
    logic [1:0] ped_a, ped_b;
    logic [3:0] cnt_a, cnt_b;
    logic       req_a, req_b, cut_a, cut_b, fault;

    int errors = 0;
    int checks = 0;
    logic [16:0] sb_q[$];
    logic [16:0] obs;

    localparam logic [1:0] PK = 2'b00;
    localparam logic [1:0] PD = 2'b01;
    localparam logic [1:0] PW = 2'b10;
    localparam logic [1:0] PF = 2'b11;

    always #5 clk = ~clk;

    ped_signal_ctl #(.WALK_CYC(2), .FLASH_CYC(2)) dut (
        .clk(clk), .reset(reset), .TL(TL), .btn_a(btn_a), .btn_b(btn_b),
        .ped_a(ped_a), .ped_b(ped_b), .cnt_a(cnt_a), .cnt_b(cnt_b),
        .req_a(req_a), .req_b(req_b), .cut_a(cut_a), .cut_b(cut_b),
        .fault(fault)
    );

    assign obs = {ped_a, ped_b, cnt_a, cnt_b, req_a, req_b, cut_a, cut_b, fault};

    function automatic logic [16:0] ev(input logic [1:0] pa, input logic [1:0] pb,
                                       input logic [3:0] ca, input logic [3:0] cb,
                                       input logic ra, input logic rb,
                                       input logic xa, input logic xb, input logic f);
        return {pa, pb, ca, cb, ra, rb, xa, xb, f};
    endfunction

    // Drive one cycle of inputs, queue the expectation, compare after the edge
    task automatic step(input string tag, input logic rst, input logic [5:0] tl,
                        input logic ba, input logic bb, input logic [16:0] exp_v);
        logic [16:0] e;
        reset = rst;
        TL    = tl;
        btn_a = ba;
        btn_b = bb;
        sb_q.push_back(exp_v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    initial begin
        reset = 1'b1; TL = 6'b0; btn_a = 1'b0; btn_b = 1'b0;

        // reset with dark lamps, then release
        step("rst0",   1, 6'b000000, 0, 0, ev(PK,PK,0,0,0,0,0,0,0));
        step("rst1",   1, 6'b000000, 0, 0, ev(PK,PK,0,0,0,0,0,0,0));
        step("rst2",   1, 6'b000000, 0, 0, ev(PK,PK,0,0,0,0,0,0,0));
        step("dark",   0, 6'b000000, 0, 0, ev(PK,PK,0,0,0,0,0,0,0));

        // full A grant: WALK, WALK, FLASH 2, FLASH 1, DONT, no cut
        step("a_req",  0, 6'b001100, 1, 0, ev(PD,PD,0,0,1,0,0,0,0));
        step("a_w1",   0, 6'b100001, 0, 0, ev(PW,PD,0,0,0,0,0,0,0));
        step("a_w2",   0, 6'b100001, 0, 0, ev(PW,PD,0,0,0,0,0,0,0));
        step("a_f2",   0, 6'b100001, 0, 0, ev(PF,PD,2,0,0,0,0,0,0));
        step("a_f1",   0, 6'b100001, 0, 0, ev(PF,PD,1,0,0,0,0,0,0));
        step("a_done", 0, 6'b100001, 0, 0, ev(PD,PD,0,0,0,0,0,0,0));
        step("a_yg",   0, 6'b010001, 0, 0, ev(PD,PD,0,0,0,0,0,0,0));

        // red-start without request, then button in the red-start cycle
        step("a_nreq", 0, 6'b100001, 0, 0, ev(PD,PD,0,0,0,0,0,0,0));
        step("a_grn",  0, 6'b001100, 0, 0, ev(PD,PD,0,0,0,0,0,0,0));
        step("a_same", 0, 6'b100001, 1, 0, ev(PW,PD,0,0,0,0,0,0,0));
        step("a_w2b",  0, 6'b100001, 0, 0, ev(PW,PD,0,0,0,0,0,0,0));
        step("a_cut",  0, 6'b010001, 0, 0, ev(PD,PD,0,0,0,0,1,0,0));
        step("a_cut0", 0, 6'b010001, 0, 0, ev(PD,PD,0,0,0,0,0,0,0));

        // B grant cut short by red ending; held button ignored in WALK
        step("b_req",  0, 6'b010001, 0, 1, ev(PD,PD,0,0,0,1,0,0,0));
        step("b_w1",   0, 6'b001100, 0, 1, ev(PD,PW,0,0,0,0,0,0,0));
        step("b_w2",   0, 6'b001100, 0, 1, ev(PD,PW,0,0,0,0,0,0,0));
        step("b_cut",  0, 6'b001010, 0, 0, ev(PD,PD,0,0,0,0,0,1,0));
        step("b_cut0", 0, 6'b001010, 0, 0, ev(PD,PD,0,0,0,0,0,0,0));

        // both greens: sticky fault, buttons ignored
        step("f_gg",   0, 6'b001001, 0, 0, ev(PD,PD,0,0,0,0,0,0,1));
        step("f_hold", 0, 6'b001100, 1, 1, ev(PD,PD,0,0,0,0,0,0,1));
        step("f_rs",   0, 6'b100001, 1, 0, ev(PD,PD,0,0,0,0,0,0,1));
        step("f_rst",  1, 6'b100001, 0, 0, ev(PK,PK,0,0,0,0,0,0,0));

        // leaving reset with red on is a red-start; then A group not one-hot
        step("r_rs",   0, 6'b100001, 1, 0, ev(PW,PD,0,0,0,0,0,0,0));
        step("f_1hot", 0, 6'b110001, 0, 0, ev(PD,PD,0,0,0,0,0,0,1));
        step("f_rst2", 1, 6'b000000, 0, 0, ev(PK,PK,0,0,0,0,0,0,0));

        // reset asserted mid-FLASH on B: no cut pulse
        step("m_w1",   0, 6'b001100, 0, 1, ev(PD,PW,0,0,0,0,0,0,0));
        step("m_w2",   0, 6'b001100, 0, 0, ev(PD,PW,0,0,0,0,0,0,0));
        step("m_f2",   0, 6'b001100, 0, 0, ev(PD,PF,0,2,0,0,0,0,0));
        step("m_rst",  1, 6'b001100, 0, 0, ev(PK,PK,0,0,0,0,0,0,0));
        step("m_post", 0, 6'b001010, 0, 0, ev(PD,PD,0,0,0,0,0,0,0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
